muldiv_unit: RTL and testbench

//  Multi-cycle RV32M execute unit for the eight M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_div_core.sv | 60 ++++++
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 op codes,
// FSM state encodings and the datapath width.
package muldiv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on unsigned magnitudes: one quotient bit per cycle, 32 cycles after load.
// quotient/remainder show the post-step values, so they are final while last is high.
module muldiv_div_core #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         abort,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         last
);

   logic [W-1:0] rem_q;
   logic [W-1:0] quo_q;
   logic [W-1:0] dvs_q;
   logic [4:0]   cnt;
   logic         active;
   logic [W:0]   rem_sh;
   logic         ge;

   // Partial remainder is always below the divisor, so the low W bits of the
   // difference are exact whenever the subtraction is taken.
   always_comb begin
      rem_sh    = {rem_q, quo_q[W-1]};
      ge        = rem_sh >= {1'b0, dvs_q};
      remainder = ge ? (rem_sh[W-1:0] - dvs_q) : rem_sh[W-1:0];
      quotient  = {quo_q[W-2:0], ge};
      last      = active && (cnt == 5'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvs_q  <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (abort) begin
         active <= 1'b0;
      end else if (load) begin
         rem_q  <= '0;
         quo_q  <= dividend;
         dvs_q  <= divisor;
         cnt    <= 5'd31;
         active <= 1'b1;
      end else if (active) begin
         rem_q <= remainder;
         quo_q <= quotient;
         cnt   <= cnt - 5'd1;
         if (cnt == 5'd0) begin
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: MUL ops done 2 cycles after accept, divides 33 (special cases 1).
// busy_o is high while an op is in flight; start_i is only taken in IDLE or DONE.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_i,
   input  logic            flush_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_o
);

   import muldiv_pkg::*;

   state_t state;
   state_t state_nxt;

   logic            accept;
   logic            is_mul_in;
   logic            is_signed_in;
   logic            div_zero;
   logic            div_ovf;
   logic            div_special;
   logic            div_start;
   logic [XLEN-1:0] special_res;
   logic [XLEN-1:0] div_dividend;
   logic [XLEN-1:0] div_divisor;

   logic [2:0]      op_f3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      op_rd;
   logic            q_neg;
   logic            r_neg;

   logic [XLEN:0]     mul_a;
   logic [XLEN:0]     mul_b;
   logic [2*XLEN-1:0] product;
   logic [XLEN-1:0]   mul_res;
   logic [XLEN-1:0]   div_res;
   logic [XLEN-1:0]   core_q;
   logic [XLEN-1:0]   core_r;
   logic              div_last;

   always_comb begin
      accept       = start_i && !flush_i && (state == ST_IDLE || state == ST_DONE);
      is_mul_in    = !funct3_i[2];
      is_signed_in = !funct3_i[0];
      div_zero     = (rs2_i == '0);
      div_ovf      = is_signed_in && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
      div_special  = !is_mul_in && (div_zero || div_ovf);
      div_start    = accept && !is_mul_in && !div_special;
      if (funct3_i[1]) begin
         special_res = div_zero ? rs1_i : '0;
      end else begin
         special_res = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
      end
      div_dividend = (is_signed_in && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
      div_divisor  = (is_signed_in && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
   end

   // 33x33 signed product: the extra top bit is the operand sign, or 0 for unsigned operands.
   always_comb begin
      mul_a   = {(op_f3 != F3_MULHU) & op_a[XLEN-1], op_a};
      mul_b   = {((op_f3 == F3_MUL) || (op_f3 == F3_MULH)) & op_b[XLEN-1], op_b};
      product = $signed({{(XLEN-1){mul_a[XLEN]}}, mul_a}) * $signed({{(XLEN-1){mul_b[XLEN]}}, mul_b});
      mul_res = (op_f3 == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
      if (op_f3[1]) begin
         div_res = r_neg ? -core_r : core_r;
      end else begin
         div_res = q_neg ? -core_q : core_q;
      end
   end

   muldiv_div_core #(
      .W (XLEN)
   ) u_div_core (
      .clk       (clk),
      .rst       (rst),
      .load      (div_start),
      .abort     (flush_i),
      .dividend  (div_dividend),
      .divisor   (div_divisor),
      .quotient  (core_q),
      .remainder (core_r),
      .last      (div_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (!accept) begin
               state_nxt = ST_IDLE;
            end else if (is_mul_in) begin
               state_nxt = ST_MUL;
            end else if (div_special) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_DIV;
            end
         end
         ST_MUL:  state_nxt = ST_DONE;
         ST_DIV:  state_nxt = div_last ? ST_DONE : ST_DIV;
         default: state_nxt = ST_IDLE;
      endcase
      if (flush_i) begin
         state_nxt = ST_IDLE;
      end
   end

   always_comb begin
      busy_o = (state == ST_MUL) || (state == ST_DIV);
      done_o = (state == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_f3    <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_rd    <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         result_o <= '0;
         rd_o     <= '0;
      end else if (accept) begin
         op_f3 <= funct3_i;
         op_a  <= rs1_i;
         op_b  <= rs2_i;
         op_rd <= rd_i;
         q_neg <= !is_mul_in && is_signed_in && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
         r_neg <= !is_mul_in && is_signed_in && rs1_i[XLEN-1];
         if (div_special) begin
            result_o <= special_res;
            rd_o     <= rd_i;
         end
      end else if (!flush_i) begin
         if (state == ST_MUL) begin
            result_o <= mul_res;
            rd_o     <= op_rd;
         end else if (state == ST_DIV && div_last) begin
            result_o <= div_res;
            rd_o     <= op_rd;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, tags, flush, reset and back-to-back issue.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic [4:0]  rd_i;
   logic        flush_i;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_o;

   int checks = 0;
   int errors = 0;

   muldiv_unit dut (
      .clk      (clk),
      .rst      (rst),
      .start_i  (start_i),
      .funct3_i (funct3_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .rd_i     (rd_i),
      .flush_i  (flush_i),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o),
      .rd_o     (rd_o)
   );

   always #5 clk = ~clk;

   // Drives one request for a single cycle, returns the cycles until done_o (capped at 60).
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat);
      @(negedge clk);
      start_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b; rd_i = rd;
      @(negedge clk);
      start_i = 1'b0;
      lat = 1;
      while (!done_o && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
      funct3_i = 3'b000; rs1_i = 32'h1234_5678; rs2_i = 32'h9; rd_i = 5'd7;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
      checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result_o); end
      checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", rd_o); end
   endtask

   task automatic test_mul();
      @(negedge clk);
      start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'hFFFF_FFFD; rd_i = 5'd5;
      @(negedge clk);
      start_i = 1'b0;
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mul_busy_t1: got %b want 1", busy_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mul_done_t1: got %b want 0", done_o); end
      @(negedge clk);
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL mul_done_t2: got %b want 1", done_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL mul_busy_t2: got %b want 0", busy_o); end
      checks++; if (result_o !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h want ffffffeb", result_o); end
      checks++; if (rd_o !== 5'd5) begin errors++; $display("FAIL mul_rd: got %0d want 5", rd_o); end
      @(negedge clk);
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mul_done_pulse: got %b want 0", done_o); end
      checks++; if (result_o !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_hold: got %h want ffffffeb", result_o); end
   endtask

   task automatic test_mulh();
      logic [2:0]  f3s [3] = '{3'b001, 3'b010, 3'b011};
      logic [31:0] exps[3] = '{32'h4000_0000, 32'hC000_0000, 32'h4000_0000};
      int lat;
      for (int i = 0; i < 3; i++) begin
         issue(f3s[i], 32'h8000_0000, 32'h8000_0000, 5'(10 + i), lat);
         checks++; if (lat !== 2) begin errors++; $display("FAIL mulh_lat[%0d]: got %0d want 2", i, lat); end
         checks++; if (result_o !== exps[i]) begin errors++; $display("FAIL mulh_result[%0d]: got %h want %h", i, result_o, exps[i]); end
         checks++; if (rd_o !== 5'(10 + i)) begin errors++; $display("FAIL mulh_rd[%0d]: got %0d want %0d", i, rd_o, 10 + i); end
      end
   endtask

   task automatic test_div();
      logic [2:0]  f3s [8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 3'b110, 3'b100, 3'b110};
      logic [31:0] as  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                              32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs  [8] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exps[8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                              32'h8000_0000, 32'h0};
      int          lats[8] = '{33, 33, 33, 33, 1, 1, 1, 1};
      int lat;
      for (int i = 0; i < 8; i++) begin
         issue(f3s[i], as[i], bs[i], 5'(i + 1), lat);
         checks++; if (lat !== lats[i]) begin errors++; $display("FAIL div_lat[%0d]: got %0d want %0d", i, lat, lats[i]); end
         checks++; if (result_o !== exps[i]) begin errors++; $display("FAIL div_result[%0d]: got %h want %h", i, result_o, exps[i]); end
         checks++; if (rd_o !== 5'(i + 1)) begin errors++; $display("FAIL div_rd[%0d]: got %0d want %0d", i, rd_o, i + 1); end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(3'b101, 32'd100, 32'd7, 5'd3, lat);
      checks++; if (result_o !== 32'd14 || rd_o !== 5'd3) begin errors++; $display("FAIL b2b_first: got %h/%0d want 0000000e/3", result_o, rd_o); end
      start_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd7; rs2_i = 32'hFFFF_FFFD; rd_i = 5'd9;
      @(negedge clk);
      start_i = 1'b0;
      checks++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL b2b_mid: got done %b busy %b want 0 1", done_o, busy_o); end
      checks++; if (rd_o !== 5'd3) begin errors++; $display("FAIL b2b_rd_hold: got %0d want 3", rd_o); end
      @(negedge clk);
      checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b want 1", done_o); end
      checks++; if (result_o !== 32'hFFFF_FFEB || rd_o !== 5'd9) begin errors++; $display("FAIL b2b_second: got %h/%0d want ffffffeb/9", result_o, rd_o); end
   endtask

   task automatic test_flush();
      int done_seen = 0;
      @(negedge clk);
      start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd4;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         start_i = (c == 5);
         if (c == 5) begin funct3_i = 3'b000; rs1_i = 32'd3; rs2_i = 32'd3; rd_i = 5'd8; end
         flush_i = (c == 10);
         if (done_o) done_seen++;
         if (c == 11) begin
            checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy_o); end
         end
      end
      checks++; if (done_seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d done cycles want 0", done_seen); end
      checks++; if (result_o !== 32'hFFFF_FFEB || rd_o !== 5'd9) begin errors++; $display("FAIL flush_hold: got %h/%0d want ffffffeb/9", result_o, rd_o); end
      // Flush and start in the same IDLE cycle: the start must be dropped.
      start_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b000; rs1_i = 32'd2; rs2_i = 32'd2; rd_i = 5'd12;
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_over_start_busy: got %b want 0", busy_o); end
      done_seen = 0;
      repeat (5) begin @(negedge clk); if (done_o) done_seen++; end
      checks++; if (done_seen !== 0) begin errors++; $display("FAIL flush_over_start_done: got %0d want 0", done_seen); end
   endtask

   task automatic test_reset_mid_op();
      int done_seen = 0;
      @(negedge clk);
      start_i = 1'b1; funct3_i = 3'b101; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd6;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         rst = (c == 4);
      end
      checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got busy %b done %b want 0 0", busy_o, done_o); end
      checks++; if (result_o !== 32'h0 || rd_o !== 5'd0) begin errors++; $display("FAIL rst_mid_data: got %h/%0d want 0/0", result_o, rd_o); end
      repeat (35) begin @(negedge clk); if (done_o) done_seen++; end
      checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d want 0", done_seen); end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_mulh();
      test_div();
      test_back_to_back();
      test_flush();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
